// File: rtl/ysyx_24080006_axi_pkg.sv
// Shared AXI4 definitions for the ysyx_24080006 slice: bus widths, burst/response
// encodings and the state types used by the SRAM responder.
package ysyx_24080006_axi_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_ID_W   = 4;
    localparam int AXI_LEN_W  = 8;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } r_state_e;

    typedef struct packed {
        w_state_e w_state;
        r_state_e r_state;
    } sram_dbg_t;

endpackage

// File: rtl/ysyx_24080006_axi_if.sv
// AXI4 bundle between a master (crossbar port) and a slave (memory responder).
// Every channel transfers on the rising clock edge where valid and ready are both 1;
// a source holds valid and its payload stable until that edge, and never waits on ready.
interface ysyx_24080006_axi;
    import ysyx_24080006_axi_pkg::*;

    logic                  awvalid;
    logic                  awready;
    logic [AXI_ADDR_W-1:0] awaddr;
    logic [AXI_ID_W-1:0]   awid;
    logic [AXI_LEN_W-1:0]  awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;

    logic                  wvalid;
    logic                  wready;
    logic [AXI_DATA_W-1:0] wdata;
    logic [3:0]            wstrb;
    logic                  wlast;

    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic [AXI_ID_W-1:0]   bid;

    logic                  arvalid;
    logic                  arready;
    logic [AXI_ADDR_W-1:0] araddr;
    logic [AXI_ID_W-1:0]   arid;
    logic [AXI_LEN_W-1:0]  arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;

    logic                  rvalid;
    logic                  rready;
    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            rresp;
    logic [AXI_ID_W-1:0]   rid;
    logic                  rlast;

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast,
        output bready,
        output arvalid, araddr, arid, arlen, arsize, arburst,
        output rready,
        input  awready, wready, bvalid, bresp, bid,
        input  arready, rvalid, rdata, rresp, rid, rlast
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast,
        input  bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        input  rready,
        output awready, wready, bvalid, bresp, bid,
        output arready, rvalid, rdata, rresp, rid, rlast
    );

endinterface

// File: rtl/ysyx_24080006_axi_beat_addr.sv
// Per-beat address helper: next burst address, protocol-error flag for the burst
// attributes, and whether the current beat falls inside the memory window.
module ysyx_24080006_axi_beat_addr
    import ysyx_24080006_axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024
) (
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr,
    output logic        err,
    output logic        in_range
);

    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;

    logic [32:0] offset;

    // The 33-bit subtraction borrows into bit 32 when addr is below the base.
    assign offset    = {1'b0, addr} - {1'b0, BASE_ADDR};
    assign in_range  = !offset[32] && (offset < SPAN);
    assign next_addr = (burst == BURST_FIXED) ? addr : addr + (32'd1 << size);
    // burst[1] covers WRAP and the reserved encoding; both run as INCR but are flagged.
    assign err       = (size > 3'd2) || burst[1];

endmodule

// File: rtl/ysyx_24080006_sram.sv
// AXI4 slave memory behind the crossbar's axi_sram port: word-addressed flop array,
// independent read/write FSMs with one outstanding transaction each, configurable read latency.
module ysyx_24080006_sram
    import ysyx_24080006_axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          READ_LAT    = 1
) (
    input  logic                clock,
    input  logic                reset,
    ysyx_24080006_axi.slave     axi,
    output sram_dbg_t           dbg
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    logic [31:0] mem [DEPTH_WORDS];

    w_state_e        w_state;
    logic [31:0]     w_addr;
    logic [3:0]      w_id;
    logic [7:0]      w_len;
    logic [2:0]      w_size;
    logic [1:0]      w_burst;
    logic            w_err;
    logic [8:0]      w_beat;
    logic            awready_q, wready_q, bvalid_q;
    logic [1:0]      bresp_q;
    logic [3:0]      bid_q;

    logic [31:0]     w_next;
    logic            w_bad, w_in, w_len_bad, w_beat_ok, w_err_next;
    logic [IDX_W-1:0] w_idx;

    r_state_e        r_state;
    logic [31:0]     r_addr;
    logic [7:0]      r_len;
    logic [2:0]      r_size;
    logic [1:0]      r_burst;
    logic [7:0]      r_beat;
    logic [CNT_W-1:0] r_cnt;
    logic            arready_q, rvalid_q;
    logic [3:0]      rid_q;

    logic [31:0]     r_next;
    logic            r_bad, r_in, r_last;
    logic [IDX_W-1:0] r_idx;

    ysyx_24080006_axi_beat_addr #(.BASE_ADDR(BASE_ADDR), .DEPTH_WORDS(DEPTH_WORDS)) u_w_addr (
        .addr(w_addr), .size(w_size), .burst(w_burst),
        .next_addr(w_next), .err(w_bad), .in_range(w_in)
    );

    ysyx_24080006_axi_beat_addr #(.BASE_ADDR(BASE_ADDR), .DEPTH_WORDS(DEPTH_WORDS)) u_r_addr (
        .addr(r_addr), .size(r_size), .burst(r_burst),
        .next_addr(r_next), .err(r_bad), .in_range(r_in)
    );

    assign w_idx      = IDX_W'((w_addr - BASE_ADDR) >> 2);
    assign r_idx      = IDX_W'((r_addr - BASE_ADDR) >> 2);
    assign w_len_bad  = (axi.wlast && (w_beat != {1'b0, w_len})) ||
                        (!axi.wlast && (w_beat == {1'b0, w_len}));
    // Beats past len+1 are swallowed until wlast; they never reach the array.
    assign w_beat_ok  = w_in && !w_bad && (w_beat <= {1'b0, w_len});
    assign w_err_next = w_err || !w_in || w_bad || w_len_bad;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_state   <= W_IDLE;
            w_addr    <= '0;
            w_id      <= '0;
            w_len     <= '0;
            w_size    <= '0;
            w_burst   <= '0;
            w_err     <= 1'b0;
            w_beat    <= '0;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            bid_q     <= '0;
        end else begin
            case (w_state)
                W_IDLE: if (axi.awvalid) begin
                    w_addr    <= axi.awaddr;
                    w_id      <= axi.awid;
                    w_len     <= axi.awlen;
                    w_size    <= axi.awsize;
                    w_burst   <= axi.awburst;
                    w_err     <= 1'b0;
                    w_beat    <= '0;
                    awready_q <= 1'b0;
                    wready_q  <= 1'b1;
                    w_state   <= W_DATA;
                end
                W_DATA: if (axi.wvalid) begin
                    w_addr <= w_next;
                    w_err  <= w_err_next;
                    if (w_beat <= {1'b0, w_len}) w_beat <= w_beat + 9'd1;
                    if (axi.wlast) begin
                        wready_q <= 1'b0;
                        bvalid_q <= 1'b1;
                        bid_q    <= w_id;
                        bresp_q  <= w_err_next ? RESP_SLVERR : RESP_OKAY;
                        w_state  <= W_RESP;
                    end
                end
                W_RESP: if (axi.bready) begin
                    bvalid_q  <= 1'b0;
                    awready_q <= 1'b1;
                    w_state   <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_state == W_DATA && axi.wvalid && w_beat_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (axi.wstrb[b]) mem[w_idx][8*b +: 8] <= axi.wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= R_IDLE;
            r_addr    <= '0;
            r_len     <= '0;
            r_size    <= '0;
            r_burst   <= '0;
            r_beat    <= '0;
            r_cnt     <= '0;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rid_q     <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (axi.arvalid) begin
                    r_addr    <= axi.araddr;
                    rid_q     <= axi.arid;
                    r_len     <= axi.arlen;
                    r_size    <= axi.arsize;
                    r_burst   <= axi.arburst;
                    r_beat    <= '0;
                    arready_q <= 1'b0;
                    // With a one-cycle latency the wait state would add a bubble, so skip it.
                    if (READ_LAT <= 1) begin
                        rvalid_q <= 1'b1;
                        r_state  <= R_DATA;
                    end else begin
                        r_cnt   <= CNT_W'(READ_LAT - 1);
                        r_state <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt <= CNT_W'(1)) begin
                        rvalid_q <= 1'b1;
                        r_state  <= R_DATA;
                    end
                end
                R_DATA: if (axi.rready) begin
                    if (r_last) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state   <= R_IDLE;
                    end else begin
                        r_addr <= r_next;
                        r_beat <= r_beat + 8'd1;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign r_last = rvalid_q && (r_beat == r_len);

    assign axi.awready = awready_q;
    assign axi.wready  = wready_q;
    assign axi.bvalid  = bvalid_q;
    assign axi.bresp   = bresp_q;
    assign axi.bid     = bid_q;
    assign axi.arready = arready_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rid     = rid_q;
    assign axi.rlast   = r_last;
    assign axi.rresp   = (rvalid_q && (!r_in || r_bad)) ? RESP_SLVERR : RESP_OKAY;
    assign axi.rdata   = (rvalid_q && r_in) ? mem[r_idx] : 32'd0;

    assign dbg.w_state = w_state;
    assign dbg.r_state = r_state;

endmodule

// File: tb/tb_ysyx_24080006_sram.sv
// Directed bench for the AXI4 SRAM responder: single/burst/strobe traffic, error cases,
// same-word read/write ordering and asynchronous reset mid-burst.
module tb_ysyx_24080006_sram;
    import ysyx_24080006_axi_pkg::*;

    localparam int TB_LAT = 2;

    logic      clock;
    logic      reset;
    sram_dbg_t dbg;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    ysyx_24080006_axi axi();

    ysyx_24080006_sram #(
        .BASE_ADDR(32'h8000_0000), .DEPTH_WORDS(1024), .READ_LAT(TB_LAT)
    ) dut (
        .clock(clock), .reset(reset), .axi(axi), .dbg(dbg)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // driver tasks
    task automatic aw_send(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        axi.awvalid = 1'b1; axi.awaddr = addr; axi.awid = id;
        axi.awlen = len; axi.awsize = size; axi.awburst = burst;
        while (!axi.awready && n < 50) begin tick(); n++; end
        if (!axi.awready) check("aw_timeout", 32'd0, 32'd1);
        tick();
        axi.awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        axi.wvalid = 1'b1; axi.wdata = data; axi.wstrb = strb; axi.wlast = last;
        while (!axi.wready && n < 50) begin tick(); n++; end
        if (!axi.wready) check("w_timeout", 32'd0, 32'd1);
        tick();
        axi.wvalid = 1'b0;
    endtask

    task automatic b_recv(input logic [1:0] resp, input logic [3:0] id, input string tag);
        int n = 0;
        axi.bready = 1'b1;
        while (!axi.bvalid && n < 50) begin tick(); n++; end
        if (!axi.bvalid) check({tag, "_timeout"}, 32'd0, 32'd1);
        check({tag, "_bresp"}, 32'(axi.bresp), 32'(resp));
        check({tag, "_bid"}, 32'(axi.bid), 32'(id));
        tick();
        axi.bready = 1'b0;
    endtask

    task automatic ar_send(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        axi.arvalid = 1'b1; axi.araddr = addr; axi.arid = id;
        axi.arlen = len; axi.arsize = size; axi.arburst = burst;
        while (!axi.arready && n < 50) begin tick(); n++; end
        if (!axi.arready) check("ar_timeout", 32'd0, 32'd1);
        tick();
        axi.arvalid = 1'b0;
    endtask

    // Called one cycle after the AR handshake; lat counts cycles since that handshake.
    task automatic wait_rvalid(input string tag, output int lat);
        lat = 1;
        while (!axi.rvalid && lat < 50) begin tick(); lat++; end
        if (!axi.rvalid) check({tag, "_rvalid_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic r_beat(input logic [1:0] resp, input logic last, input logic [3:0] id,
                          input logic chk_data, input string tag);
        int n = 0;
        logic [31:0] exp;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        axi.rready = 1'b1;
        while (!axi.rvalid && n < 50) begin tick(); n++; end
        if (!axi.rvalid) check({tag, "_timeout"}, 32'd0, 32'd1);
        if (chk_data) check({tag, "_rdata"}, axi.rdata, exp);
        check({tag, "_rresp"}, 32'(axi.rresp), 32'(resp));
        check({tag, "_rlast"}, 32'(axi.rlast), 32'(last));
        check({tag, "_rid"}, 32'(axi.rid), 32'(id));
        tick();
        axi.rready = 1'b0;
    endtask

    task automatic write_burst(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                               input logic [1:0] burst, input logic [31:0] base,
                               input logic [1:0] resp, input string tag);
        aw_send(addr, id, len, 3'd2, burst);
        for (int i = 0; i <= int'(len); i++) w_send(base + 32'(i), 4'hF, i == int'(len));
        b_recv(resp, id, tag);
    endtask

    task automatic read_burst(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst,
                              input logic [1:0] resp, input logic chk_data, input string tag);
        int lat;
        ar_send(addr, id, len, size, burst);
        wait_rvalid(tag, lat);
        for (int i = 0; i <= int'(len); i++) r_beat(resp, i == int'(len), id, chk_data, tag);
    endtask

    initial begin
        int lat;
        reset = 1'b1;
        axi.awvalid = 0; axi.awaddr = 0; axi.awid = 0; axi.awlen = 0; axi.awsize = 0; axi.awburst = 0;
        axi.wvalid = 0; axi.wdata = 0; axi.wstrb = 0; axi.wlast = 0; axi.bready = 0;
        axi.arvalid = 0; axi.araddr = 0; axi.arid = 0; axi.arlen = 0; axi.arsize = 0; axi.arburst = 0;
        axi.rready = 0;
        tick(); tick();
        reset = 1'b0;
        tick();

        check("rst_awready", 32'(axi.awready), 32'd1);
        check("rst_arready", 32'(axi.arready), 32'd1);
        check("rst_wready", 32'(axi.wready), 32'd0);
        check("rst_bvalid", 32'(axi.bvalid), 32'd0);
        check("rst_rvalid", 32'(axi.rvalid), 32'd0);
        check("rst_rdata", axi.rdata, 32'd0);

        // W beat offered before any AW must stall
        axi.wvalid = 1'b1; axi.wdata = 32'hDEAD_BEEF; axi.wstrb = 4'hF; axi.wlast = 1'b1;
        tick(); tick();
        check("w_stall", 32'(axi.wready), 32'd0);
        axi.wvalid = 1'b0;

        // single write then read
        aw_send(32'h8000_0010, 4'h3, 8'd0, 3'd2, BURST_INCR);
        check("wready_rise", 32'(axi.wready), 32'd1);
        check("awready_low", 32'(axi.awready), 32'd0);
        w_send(32'hDEAD_BEEF, 4'hF, 1'b1);
        check("bvalid_next", 32'(axi.bvalid), 32'd1);
        b_recv(RESP_OKAY, 4'h3, "single_b");
        check("awready_back", 32'(axi.awready), 32'd1);
        ar_send(32'h8000_0010, 4'h6, 8'd0, 3'd2, BURST_INCR);
        check("arready_low", 32'(axi.arready), 32'd0);
        wait_rvalid("single_r", lat);
        check("read_latency", 32'(lat), 32'(TB_LAT));
        exp_q.push_back(32'hDEAD_BEEF);
        r_beat(RESP_OKAY, 1'b1, 4'h6, 1'b1, "single_r");
        check("arready_back", 32'(axi.arready), 32'd1);

        // byte strobe merge
        write_burst(32'h8000_0020, 4'h1, 8'd0, BURST_INCR, 32'h1122_3344, RESP_OKAY, "pre_b");
        aw_send(32'h8000_0020, 4'h1, 8'd0, 3'd2, BURST_INCR);
        w_send(32'h0000_AA00, 4'b0010, 1'b1);
        b_recv(RESP_OKAY, 4'h1, "strb_b");
        exp_q.push_back(32'h1122_AA44);
        read_burst(32'h8000_0020, 4'h1, 8'd0, 3'd2, BURST_INCR, RESP_OKAY, 1'b1, "strb_r");

        // INCR burst of 4 with rready toggling
        write_burst(32'h8000_0100, 4'h2, 8'd3, BURST_INCR, 32'hA000_0000, RESP_OKAY, "incr_b");
        ar_send(32'h8000_0100, 4'h2, 8'd3, 3'd2, BURST_INCR);
        wait_rvalid("incr_r", lat);
        check("incr_latency", 32'(lat), 32'(TB_LAT));
        for (int i = 0; i < 4; i++) begin
            axi.rready = 1'b0;
            check("incr_data", axi.rdata, 32'hA000_0000 + 32'(i));
            check("incr_last", 32'(axi.rlast), 32'(i == 3));
            tick();
            check("incr_hold_valid", 32'(axi.rvalid), 32'd1);
            check("incr_hold_data", axi.rdata, 32'hA000_0000 + 32'(i));
            check("incr_hold_last", 32'(axi.rlast), 32'(i == 3));
            axi.rready = 1'b1;
            tick();
        end
        axi.rready = 1'b0;
        check("incr_done", 32'(axi.rvalid), 32'd0);

        // FIXED burst keeps hitting one word
        write_burst(32'h8000_0030, 4'h4, 8'd1, BURST_FIXED, 32'h0000_0001, RESP_OKAY, "fixed_b");
        exp_q.push_back(32'h0000_0002);
        exp_q.push_back(32'h0000_0002);
        read_burst(32'h8000_0030, 4'h4, 8'd1, 3'd2, BURST_FIXED, RESP_OKAY, 1'b1, "fixed_r");

        // out of range read
        exp_q.push_back(32'd0);
        read_burst(32'h0000_1000, 4'h8, 8'd0, 3'd2, BURST_INCR, RESP_SLVERR, 1'b1, "oor_r");

        // out of range write must not alias onto word 0; last word is still valid
        write_burst(32'h8000_0000, 4'h1, 8'd0, BURST_INCR, 32'h55AA_55AA, RESP_OKAY, "w0_b");
        write_burst(32'h8000_1000, 4'h1, 8'd0, BURST_INCR, 32'h1234_5678, RESP_SLVERR, "oor_b");
        exp_q.push_back(32'h55AA_55AA);
        read_burst(32'h8000_0000, 4'h1, 8'd0, 3'd2, BURST_INCR, RESP_OKAY, 1'b1, "w0_r");
        write_burst(32'h8000_0FFC, 4'h1, 8'd0, BURST_INCR, 32'hCAFE_F00D, RESP_OKAY, "top_b");
        exp_q.push_back(32'hCAFE_F00D);
        read_burst(32'h8000_0FFC, 4'h1, 8'd0, 3'd2, BURST_INCR, RESP_OKAY, 1'b1, "top_r");

        // bad size on read, WRAP on write
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        read_burst(32'h8000_0010, 4'h5, 8'd1, 3'd3, BURST_INCR, RESP_SLVERR, 1'b0, "size3_r");
        write_burst(32'h8000_0050, 4'hA, 8'd0, BURST_WRAP, 32'h0, RESP_SLVERR, "wrap_b");

        // early wlast
        aw_send(32'h8000_0040, 4'h5, 8'd3, 3'd2, BURST_INCR);
        w_send(32'h1, 4'hF, 1'b0);
        w_send(32'h2, 4'hF, 1'b1);
        check("short_bvalid", 32'(axi.bvalid), 32'd1);
        b_recv(RESP_SLVERR, 4'h5, "short_b");
        write_burst(32'h8000_0044, 4'h6, 8'd0, BURST_INCR, 32'h77, RESP_OKAY, "after_b");

        // same-word write during a presented read beat
        write_burst(32'h8000_0060, 4'h2, 8'd0, BURST_INCR, 32'h0BAD_F00D, RESP_OKAY, "raw_pre");
        aw_send(32'h8000_0060, 4'h2, 8'd0, 3'd2, BURST_INCR);
        ar_send(32'h8000_0060, 4'h3, 8'd0, 3'd2, BURST_INCR);
        wait_rvalid("raw_r", lat);
        axi.wvalid = 1'b1; axi.wdata = 32'h600D_CAFE; axi.wstrb = 4'hF; axi.wlast = 1'b1;
        check("raw_old", axi.rdata, 32'h0BAD_F00D);
        tick();
        axi.wvalid = 1'b0;
        check("raw_new", axi.rdata, 32'h600D_CAFE);
        b_recv(RESP_OKAY, 4'h2, "raw_b");
        exp_q.push_back(32'h600D_CAFE);
        r_beat(RESP_OKAY, 1'b1, 4'h3, 1'b1, "raw_r");

        // asynchronous reset in the middle of both bursts
        aw_send(32'h8000_0200, 4'h9, 8'd1, 3'd2, BURST_INCR);
        w_send(32'h1, 4'hF, 1'b0);
        ar_send(32'h8000_0100, 4'h7, 8'd3, 3'd2, BURST_INCR);
        wait_rvalid("mid_r", lat);
        exp_q.push_back(32'hA000_0000);
        r_beat(RESP_OKAY, 1'b0, 4'h7, 1'b1, "mid_r");
        #2;
        reset = 1'b1;
        #1;
        check("ar_awready", 32'(axi.awready), 32'd1);
        check("ar_arready", 32'(axi.arready), 32'd1);
        check("ar_wready", 32'(axi.wready), 32'd0);
        check("ar_bvalid", 32'(axi.bvalid), 32'd0);
        check("ar_rvalid", 32'(axi.rvalid), 32'd0);
        check("ar_rlast", 32'(axi.rlast), 32'd0);
        check("ar_bresp", 32'(axi.bresp), 32'd0);
        check("ar_rresp", 32'(axi.rresp), 32'd0);
        check("ar_bid", 32'(axi.bid), 32'd0);
        check("ar_rid", 32'(axi.rid), 32'd0);
        check("ar_rdata", axi.rdata, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        write_burst(32'h8000_0070, 4'hC, 8'd0, BURST_INCR, 32'h0F0F_0F0F, RESP_OKAY, "post_b");
        exp_q.push_back(32'h0F0F_0F0F);
        read_burst(32'h8000_0070, 4'hD, 8'd0, 3'd2, BURST_INCR, RESP_OKAY, 1'b1, "post_r");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
